// File: rtl/ex_lfsr8_pkg.sv
// Shared definitions for the 8-bit LFSR example-driver pattern generator and checker.
package ex_lfsr8_pkg;

  localparam int unsigned CNT_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SYNC,
    ST_CHECK,
    ST_DONE
  } state_t;

  // Bit-exact next-state function; the generator must use this same function.
  function automatic logic [7:0] lfsr8_next(input logic [7:0] e);
    lfsr8_next = {e[6], e[5], e[4], e[3] ^ e[7], e[2] ^ e[7], e[1] ^ e[7], e[0], e[7]};
  endfunction

endpackage

// File: rtl/ex_lfsr8_checker.sv
// Read-back checker: regenerates the LFSR8 pattern, compares each valid word,
// counts mismatches and reports done/pass to the example driver FSM.
module ex_lfsr8_checker
  import ex_lfsr8_pkg::*;
#(
  parameter logic [31:0] SEED      = 32,
  parameter int unsigned SYNC_MODE = 0,
  parameter int unsigned NUM_WORDS = 256
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             start,
  input  logic             data_valid,
  input  logic [7:0]       data_in,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] word_count,
  output logic [7:0]       first_err_data,
  output logic [7:0]       first_err_exp
);

  localparam logic [7:0] SEED8 = SEED[7:0];

  state_t           state;
  logic [7:0]       expected;
  logic             fail;
  logic             mismatch;
  logic             last_word;
  logic [CNT_W-1:0] word_count_inc;

  always_comb begin
    mismatch       = (state == ST_CHECK) && data_valid && (data_in != expected);
    last_word      = (NUM_WORDS != 0) && ((32'(word_count) + 32'd1) == NUM_WORDS);
    word_count_inc = (word_count == '1) ? word_count : word_count + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= ST_IDLE;
      expected       <= SEED8;
      fail           <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      err_pulse      <= 1'b0;
      err_count      <= '0;
      word_count     <= '0;
      first_err_data <= '0;
      first_err_exp  <= '0;
    end else begin
      err_pulse <= 1'b0;
      if (!enable) begin
        state    <= ST_IDLE;
        expected <= SEED8;
        busy     <= 1'b0;
        done     <= 1'b0;
      end else if (start) begin
        state          <= (SYNC_MODE != 0) ? ST_SYNC : ST_CHECK;
        expected       <= SEED8;
        fail           <= 1'b0;
        busy           <= 1'b1;
        done           <= 1'b0;
        pass           <= 1'b0;
        err_count      <= '0;
        word_count     <= '0;
        first_err_data <= '0;
        first_err_exp  <= '0;
      end else begin
        unique case (state)
          ST_SYNC: begin
            if (data_valid) begin
              expected   <= lfsr8_next(data_in);
              word_count <= word_count_inc;
              if (last_word) begin
                state <= ST_DONE;
                busy  <= 1'b0;
                done  <= 1'b1;
                pass  <= !fail;
              end else begin
                state <= ST_CHECK;
              end
            end
          end
          ST_CHECK: begin
            if (data_valid) begin
              // Always advance from the local pattern so a corrupted word costs one error.
              expected   <= lfsr8_next(expected);
              word_count <= word_count_inc;
              if (mismatch) begin
                err_pulse <= 1'b1;
                fail      <= 1'b1;
                if (err_count != '1) err_count <= err_count + CNT_W'(1);
                if (!fail) begin
                  first_err_data <= data_in;
                  first_err_exp  <= expected;
                end
              end
              if (last_word) begin
                state <= ST_DONE;
                busy  <= 1'b0;
                done  <= 1'b1;
                pass  <= !(fail || mismatch);
              end
            end
          end
          ST_IDLE, ST_DONE: ;
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ex_lfsr8_checker.sv
// Scoreboard bench: three checker configurations share one randomized stimulus stream.
module tb_ex_lfsr8_checker;

  localparam int NI = 3;
  localparam logic [7:0] TB_SEED = 8'h20;
  localparam int M_IDLE = 0, M_SYNC = 1, M_CHECK = 2, M_DONE = 3;

  typedef struct {int inst; logic [7:0] d; logic [7:0] e; logic [15:0] ec;} err_ev_t;
  typedef struct {int inst; logic pass; logic [15:0] ec; logic [15:0] wc;} done_ev_t;

  logic clk = 1'b0;
  logic reset = 1'b1, enable = 1'b0, start = 1'b0, data_valid = 1'b0;
  logic [7:0] data_in = '0;

  logic        busy_w [NI];
  logic        done_w [NI];
  logic        pass_w [NI];
  logic        ep_w   [NI];
  logic [15:0] ec_w   [NI];
  logic [15:0] wc_w   [NI];
  logic [7:0]  fed_w  [NI];
  logic [7:0]  fee_w  [NI];

  int n_tests = 0;
  int n_fail  = 0;

  int          num_words [NI] = '{4, 3, 0};
  bit          sync_mode [NI] = '{1'b0, 1'b1, 1'b0};
  int          ms   [NI];
  logic [7:0]  mexp [NI];
  int          mwc  [NI];
  int          mec  [NI];
  bit          mfail[NI];
  logic [7:0]  mfd  [NI];
  logic [7:0]  mfe  [NI];

  err_ev_t  errq [$];
  done_ev_t doneq[$];
  logic     prev_done [NI];

  always #5 clk = ~clk;

  ex_lfsr8_checker #(.SEED(32), .SYNC_MODE(0), .NUM_WORDS(4)) u_seed (
    .clk(clk), .reset(reset), .enable(enable), .start(start), .data_valid(data_valid),
    .data_in(data_in), .busy(busy_w[0]), .done(done_w[0]), .pass(pass_w[0]),
    .err_pulse(ep_w[0]), .err_count(ec_w[0]), .word_count(wc_w[0]),
    .first_err_data(fed_w[0]), .first_err_exp(fee_w[0]));

  ex_lfsr8_checker #(.SEED(32), .SYNC_MODE(1), .NUM_WORDS(3)) u_sync (
    .clk(clk), .reset(reset), .enable(enable), .start(start), .data_valid(data_valid),
    .data_in(data_in), .busy(busy_w[1]), .done(done_w[1]), .pass(pass_w[1]),
    .err_pulse(ep_w[1]), .err_count(ec_w[1]), .word_count(wc_w[1]),
    .first_err_data(fed_w[1]), .first_err_exp(fee_w[1]));

  ex_lfsr8_checker #(.SEED(32), .SYNC_MODE(0), .NUM_WORDS(0)) u_unb (
    .clk(clk), .reset(reset), .enable(enable), .start(start), .data_valid(data_valid),
    .data_in(data_in), .busy(busy_w[2]), .done(done_w[2]), .pass(pass_w[2]),
    .err_pulse(ep_w[2]), .err_count(ec_w[2]), .word_count(wc_w[2]),
    .first_err_data(fed_w[2]), .first_err_exp(fee_w[2]));

  // Galois form of the polynomial x^8+x^4+x^3+x^2+1.
  function automatic logic [7:0] ref_next(input logic [7:0] e);
    ref_next = {e[6:0], 1'b0} ^ (e[7] ? 8'h1D : 8'h00);
  endfunction

  task automatic chk(input string name, input int i, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s[%0d] @%0t: got %0h expected %0h", name, i, $time, act, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < NI; i++) begin
      ms[i] = M_IDLE; mexp[i] = TB_SEED; mwc[i] = 0; mec[i] = 0;
      mfail[i] = 1'b0; mfd[i] = '0; mfe[i] = '0;
    end
  endfunction

  // Predicts what the next clock edge does to instance i.
  function automatic void model_step(input int i, input bit en, input bit st, input bit v, input logic [7:0] d);
    if (!en) begin
      ms[i] = M_IDLE; mexp[i] = TB_SEED;
      return;
    end
    if (st) begin
      mwc[i] = 0; mec[i] = 0; mfail[i] = 1'b0; mfd[i] = '0; mfe[i] = '0;
      mexp[i] = TB_SEED;
      ms[i] = sync_mode[i] ? M_SYNC : M_CHECK;
      return;
    end
    if (!v || !(ms[i] == M_SYNC || ms[i] == M_CHECK)) return;
    if (ms[i] == M_SYNC) begin
      mexp[i] = ref_next(d);
      ms[i] = M_CHECK;
    end else begin
      if (d !== mexp[i]) begin
        if (mec[i] < 65535) mec[i]++;
        if (!mfail[i]) begin mfd[i] = d; mfe[i] = mexp[i]; end
        mfail[i] = 1'b1;
        errq.push_back('{inst: i, d: mfd[i], e: mfe[i], ec: 16'(mec[i])});
      end
      mexp[i] = ref_next(mexp[i]);
    end
    if (mwc[i] < 65535) mwc[i]++;
    if (num_words[i] != 0 && mwc[i] == num_words[i]) begin
      ms[i] = M_DONE;
      doneq.push_back('{inst: i, pass: !mfail[i], ec: 16'(mec[i]), wc: 16'(mwc[i])});
    end
  endfunction

  task automatic check_all();
    for (int i = 0; i < NI; i++) begin
      chk("busy", i, 32'(busy_w[i]), 32'(ms[i] == M_SYNC || ms[i] == M_CHECK));
      chk("done", i, 32'(done_w[i]), 32'(ms[i] == M_DONE));
      chk("err_count", i, 32'(ec_w[i]), 32'(mec[i]));
      chk("word_count", i, 32'(wc_w[i]), 32'(mwc[i]));
      chk("first_err_data", i, 32'(fed_w[i]), 32'(mfd[i]));
      chk("first_err_exp", i, 32'(fee_w[i]), 32'(mfe[i]));
    end
  endtask

  task automatic cycle(input bit en, input bit st, input bit v, input logic [7:0] d);
    enable = en; start = st; data_valid = v; data_in = d;
    for (int i = 0; i < NI; i++) model_step(i, en, st, v, d);
    @(posedge clk); #1;
    check_all();
  endtask

  task automatic do_reset();
    reset = 1'b1; enable = 1'b0; start = 1'b0; data_valid = 1'b0; data_in = '0;
    model_reset();
    @(posedge clk); #1;
    reset = 1'b0;
    check_all();
    for (int i = 0; i < NI; i++) begin
      chk("reset_pass", i, 32'(pass_w[i]), 32'd0);
      chk("reset_err_pulse", i, 32'(ep_w[i]), 32'd0);
    end
  endtask

  // Monitor: pops expected err_pulse / done events as the DUTs present them.
  always @(negedge clk) begin
    for (int i = 0; i < NI; i++) begin
      if (ep_w[i] === 1'b1) begin
        if (errq.size() == 0 || errq[0].inst != i) begin
          chk("err_pulse_unexpected", i, 32'd1, 32'd0);
        end else begin
          err_ev_t ev;
          ev = errq.pop_front();
          chk("pulse_err_count", i, 32'(ec_w[i]), 32'(ev.ec));
          chk("pulse_first_err_data", i, 32'(fed_w[i]), 32'(ev.d));
          chk("pulse_first_err_exp", i, 32'(fee_w[i]), 32'(ev.e));
        end
      end
      if (done_w[i] === 1'b1 && prev_done[i] !== 1'b1) begin
        if (doneq.size() == 0 || doneq[0].inst != i) begin
          chk("done_unexpected", i, 32'd1, 32'd0);
        end else begin
          done_ev_t dv;
          dv = doneq.pop_front();
          chk("done_pass", i, 32'(pass_w[i]), 32'(dv.pass));
          chk("done_err_count", i, 32'(ec_w[i]), 32'(dv.ec));
          chk("done_word_count", i, 32'(wc_w[i]), 32'(dv.wc));
        end
      end
      prev_done[i] = done_w[i];
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] pat;
    logic [7:0] d;
    int k;
    do_reset();
    repeat (2) cycle(1, 0, 0, 8'h00);

    // Clean seeded run.
    cycle(1, 1, 0, 8'h00);
    cycle(1, 0, 1, 8'h20); cycle(1, 0, 1, 8'h40); cycle(1, 0, 1, 8'h80); cycle(1, 0, 1, 8'h1D);
    chk("seed_done", 0, 32'(done_w[0]), 32'd1);
    chk("seed_pass", 0, 32'(pass_w[0]), 32'd1);
    chk("seed_word_count", 0, 32'(wc_w[0]), 32'd4);
    repeat (2) cycle(1, 0, 0, 8'h00);

    // Single corrupted third word.
    cycle(1, 1, 0, 8'h00);
    cycle(1, 0, 1, 8'h20); cycle(1, 0, 1, 8'h40); cycle(1, 0, 1, 8'h81);
    chk("single_err_pulse", 0, 32'(ep_w[0]), 32'd1);
    cycle(1, 0, 1, 8'h1D);
    chk("single_err_no_pulse_w4", 0, 32'(ep_w[0]), 32'd0);
    chk("single_err_count", 0, 32'(ec_w[0]), 32'd1);
    chk("single_first_data", 0, 32'(fed_w[0]), 32'h81);
    chk("single_first_exp", 0, 32'(fee_w[0]), 32'h80);
    chk("single_pass", 0, 32'(pass_w[0]), 32'd0);
    repeat (2) cycle(1, 0, 0, 8'h00);

    // Self-synchronising run from mid-sequence.
    cycle(1, 1, 0, 8'h00);
    cycle(1, 0, 1, 8'h1D); cycle(1, 0, 1, 8'h3A); cycle(1, 0, 1, 8'h74);
    chk("sync_done", 1, 32'(done_w[1]), 32'd1);
    chk("sync_pass", 1, 32'(pass_w[1]), 32'd1);
    chk("sync_word_count", 1, 32'(wc_w[1]), 32'd3);
    repeat (2) cycle(1, 0, 0, 8'h00);

    // Valid gap between 0x40 and 0x80.
    cycle(1, 1, 0, 8'h00);
    cycle(1, 0, 1, 8'h20); cycle(1, 0, 1, 8'h40);
    repeat (3) cycle(1, 0, 0, 8'h80);
    cycle(1, 0, 1, 8'h80); cycle(1, 0, 1, 8'h1D);
    chk("gap_pass", 0, 32'(pass_w[0]), 32'd1);
    chk("gap_err_count", 2, 32'(ec_w[2]), 32'd0);
    repeat (2) cycle(1, 0, 0, 8'h00);

    // Randomized runs: gaps, bit flips, restarts, enable drops, valid during start.
    for (int r = 0; r < 30; r++) begin
      cycle(1, 1, 1'($urandom_range(0, 1)), 8'($urandom));
      pat = TB_SEED;
      for (int s = 0; s < int'($urandom_range(3, 14)); s++) begin
        k = $urandom_range(0, 19);
        if (k == 0) begin
          cycle(1, 1, 1'($urandom_range(0, 1)), 8'($urandom));
          pat = TB_SEED;
        end else if (k == 1) begin
          cycle(0, 1'($urandom_range(0, 1)), 1, pat);
        end else if (k < 6) begin
          cycle(1, 0, 0, 8'($urandom));
        end else begin
          d = pat;
          if ($urandom_range(0, 4) == 0) d = d ^ 8'(1 << $urandom_range(0, 7));
          cycle(1, 0, 1, d);
          pat = ref_next(pat);
        end
      end
    end

    // Saturation on the unbounded instance.
    cycle(1, 1, 0, 8'h00);
    repeat (70000) cycle(1, 0, 1, 8'h00);
    chk("sat_err_count", 2, 32'(ec_w[2]), 32'h0000_FFFF);
    chk("sat_word_count", 2, 32'(wc_w[2]), 32'h0000_FFFF);
    chk("sat_busy", 2, 32'(busy_w[2]), 32'd1);

    // Restart mid-run, then a matching first word.
    cycle(1, 1, 0, 8'h00);
    chk("restart_err_count", 2, 32'(ec_w[2]), 32'd0);
    chk("restart_word_count", 2, 32'(wc_w[2]), 32'd0);
    cycle(1, 0, 1, 8'h20);
    chk("restart_word_ok", 2, 32'(ec_w[2]), 32'd0);
    cycle(1, 0, 0, 8'h00);
    chk("restart_no_pulse", 2, 32'(ep_w[2]), 32'd0);

    // Enable drop forces idle.
    cycle(0, 0, 1, 8'h40);
    chk("disable_busy", 2, 32'(busy_w[2]), 32'd0);
    cycle(0, 0, 0, 8'h00);

    do_reset();
    cycle(1, 0, 0, 8'h00);
    cycle(1, 0, 0, 8'h00);

    chk("err_queue_drained", 0, 32'(errq.size()), 32'd0);
    chk("done_queue_drained", 0, 32'(doneq.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ex_lfsr8_checker.md
Name: ex_lfsr8_checker

Overview:
- Read-side counterpart of the example-driver 8-bit LFSR pattern generator.
- Consumes read-back words from the memory interface and regenerates the expected pattern with the same polynomial.
- Compares each word against that pattern, counts errors and reports pass/fail to the example driver FSM.
- Supports two modes: seeded (expected pattern starts at SEED) or self-synchronising (expected pattern loads from the first received word).

Parameters:
SEED, 32, initial expected value (bits [7:0] used)
SYNC_MODE, 0, 0 = seeded compare; 1 = sync expected pattern from the first valid word
NUM_WORDS, 256, words checked per run; 0 = unbounded (run until enable drops)

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
enable  input  1  checker enabled; low forces IDLE and reloads SEED
start  input  1  single-cycle pulse; begins or restarts a run
data_valid  input  1  data_in valid this cycle
data_in  input  8  read-back word
busy  output  1  run in progress (SYNC or CHECK)
done  output  1  run complete; held until the next start or until enable drops
pass  output  1  done and no mismatch seen
err_pulse  output  1  one-cycle pulse per mismatching word
err_count  output  16  mismatch count, saturating
word_count  output  16  valid words consumed this run
first_err_data  output  8  data_in of the first mismatch
first_err_exp  output  8  expected value at the first mismatch

Behaviour:
- LFSR next-state function, n = next(e):
  - n0 = e7; n1 = e0; n2 = e1^e7; n3 = e2^e7; n4 = e3^e7; n5 = e4; n6 = e5; n7 = e6.
  - Sequence from 0x20: 0x20, 0x40, 0x80, 0x1D, 0x3A, ...
- Reset (when reset=1 at a clk edge):
  - State IDLE, expected = SEED[7:0].
  - All outputs and counters 0; first_err_* = 0.
- States: IDLE, SYNC, CHECK, DONE.
- enable=0, any state:
  - Next state IDLE, expected = SEED.
  - busy and done clear.
  - Counters, pass and first_err_* retain their values.
- start=1 with enable=1, any state (restarts a run in progress):
  - Clear err_count, word_count, fail flag, first_err_* and done.
  - expected = SEED.
  - Next state SYNC if SYNC_MODE=1, else CHECK.
  - data_valid in the start cycle is ignored.
- SYNC:
  - On data_valid: expected <= next(data_in); word_count++; no compare.
  - Next state CHECK.
- CHECK, on data_valid:
  - Compare data_in against expected.
  - Always expected <= next(expected); never resync from data. A single bit error costs exactly one error.
  - word_count++.
  - On mismatch: err_pulse=1 on the following cycle (registered; latency 1); err_count++ saturating at 0xFFFF; fail flag set.
  - If this is the first mismatch of the run, capture first_err_data and first_err_exp.
- Run completion: when word_count would reach NUM_WORDS (NUM_WORDS != 0), the same edge moves to DONE.
  - done=1 and pass=!fail, both registered. That edge also registers the last word's compare result.
- DONE: data_valid ignored; hold until start or enable low.
- data_valid low in SYNC/CHECK: pause; expected holds.
- word_count: saturates at 0xFFFF when NUM_WORDS=0.
- busy: 1 exactly in SYNC and CHECK.

Decomposition:
- Shared package (ex_lfsr8_pkg):
  - state enum;
  - LFSR8 next-state function (shared with the generator for bit-exact matching);
  - counter width constant CNT_W=16.
- No sub-module: a single flat module. The next-state function comes from the package.

Test Plan:
- Seeded, NUM_WORDS=4: start, then feed 0x20, 0x40, 0x80, 0x1D on consecutive cycles -> done=1 and pass=1 on the edge after the 4th word; err_count=0; word_count=4.
- Single error: same stimulus with the 3rd word 0x81 -> one err_pulse on the cycle after word 3; err_count=1; first_err_data=0x81; first_err_exp=0x80; pass=0. Word 4 (0x1D) still matches.
- SYNC_MODE=1: start, feed 0x1D, 0x3A, 0x74 -> no errors; word_count=3; after the first word, expected held 0x3A.
- Gaps: seeded run with data_valid low for 3 cycles between words 0x40 and 0x80 -> no errors; expected holds across the gap.
- Saturation and control: NUM_WORDS=0 with constant 0x00 input for 70000 words -> err_count sticks at 0xFFFF. Then start mid-run -> counters 0; the next word 0x20 passes. Then enable low -> busy=0, state IDLE. Then reset=1 -> all outputs 0.
